load_use_scoreboard: RTL and testbench

LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

---
 rtl/isa_pkg.sv | 66 ++++++
 rtl/sb_counter_cell.sv | 32 +++
 rtl/load_use_scoreboard.sv | 91 +++++++++
 tb/tb_load_use_scoreboard.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the load-use scoreboard: opcode values, the
// function-code ranges that select which registers an ALU op reads, and the
// decode helper that turns a raw 16-bit instruction into source-use flags.
package isa_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_STORE  = 2'b01,
    OP_BRANCH = 2'b10,
    OP_ALU    = 2'b11
  } opcode_e;

  // ALU function ranges. Register-register forms start at func 0000.
  localparam logic [3:0] FUNC_RR_HI   = 4'h5;  // 0000..0101 read rs and rd
  localparam logic [3:0] FUNC_RD_ONLY = 4'h6;  // 0110 reads rd only
  localparam logic [3:0] FUNC_RS_LO   = 4'h8;  // 1000..1011 read rs only
  localparam logic [3:0] FUNC_RS_HI   = 4'hB;

  // Instruction field layout, most significant field first.
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [3:0] func;
    logic [3:0] imm;
  } instr_t;

  // Which register fields an instruction reads, and whether it writes rd
  // through the load path.
  typedef struct packed {
    logic use_rs;
    logic use_rd;
    logic is_load;
  } src_use_t;

  function automatic src_use_t decode_src_use(input logic [15:0] raw);
    instr_t   ins;
    src_use_t use_f;
    ins   = raw;
    use_f = '0;
    case (opcode_e'(ins.op))
      OP_LOAD: begin
        use_f.use_rs  = 1'b1;
        use_f.is_load = 1'b1;
      end
      OP_STORE: begin
        // Stores read the address base and the data register.
        use_f.use_rs = 1'b1;
        use_f.use_rd = 1'b1;
      end
      OP_ALU: begin
        if (ins.func <= FUNC_RR_HI) begin
          use_f.use_rs = 1'b1;
          use_f.use_rd = 1'b1;
        end else if (ins.func == FUNC_RD_ONLY) begin
          use_f.use_rd = 1'b1;
        end else if ((ins.func >= FUNC_RS_LO) && (ins.func <= FUNC_RS_HI)) begin
          use_f.use_rs = 1'b1;
        end
      end
      default: ;  // branches and unlisted ALU functions read nothing
    endcase
    return use_f;
  endfunction

endpackage

// File: rtl/sb_counter_cell.sv
// One register's load-latency countdown. Busy while the count is non-zero.
module sb_counter_cell #(
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic busy
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  logic [CW-1:0] r_count;

  // Countdown: reset/flush clear, a new load reloads (wins over decrement),
  // otherwise count down to zero and stay there.
  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (set) begin
      r_count <= CW'(LOAD_LAT);
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign busy = (r_count != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard. Tracks registers that are waiting for load data,
// stalls the issue stage when a presented instruction reads one of them, and
// counts stalled cycles in a saturating performance counter.
module load_use_scoreboard
  import isa_pkg::*;
#(
  parameter int NREG     = 8,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [15:0]      issue_instr,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  busy_mask,
  output logic [CNT_W-1:0] stall_count
);

  instr_t           w_instr;
  src_use_t         w_use;
  logic [NREG-1:0]  w_busy;
  logic [NREG-1:0]  w_set;
  logic             w_rs_busy;
  logic             w_rd_busy;
  logic             w_hazard;
  logic             w_live;
  logic             w_accept;
  logic             w_load_accept;
  logic             w_unused;
  logic [CNT_W-1:0] r_stall_count;

  assign w_instr  = issue_instr;
  assign w_use    = decode_src_use(issue_instr);
  // The low nibble is an immediate the scoreboard never inspects.
  assign w_unused = ^w_instr.imm;

  // Look up the busy flag of the rs and rd fields. Field values that name a
  // register beyond NREG are never tracked, so they never report busy.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rs_busy = 1'b0;
    w_rd_busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (int'(w_instr.rs) == r) w_rs_busy = w_busy[r];
      if (int'(w_instr.rd) == r) w_rd_busy = w_busy[r];
    end
  end

  assign w_hazard      = (w_use.use_rs && w_rs_busy) || (w_use.use_rd && w_rd_busy);
  // Reset and flush both mask the issue slot: nothing stalls, nothing accepts.
  assign w_live        = issue_valid && !flush && !rst;
  assign stall         = w_live && w_hazard;
  assign w_accept      = w_live && !w_hazard;
  assign w_load_accept = w_accept && w_use.is_load;

  // Route an accepted load to the counter of its destination register.
  always_comb begin
    w_set = '0;
    for (int r = 0; r < NREG; r++) begin
      if (int'(w_instr.rd) == r) w_set[r] = w_load_accept;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    sb_counter_cell #(
      .LOAD_LAT (LOAD_LAT)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .set  (w_set[g]),
      .clr  (flush),
      .busy (w_busy[g])
    );
  end

  // Saturating count of stalled cycles; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign busy_mask   = w_busy;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard. Two instances: A uses defaults
// (LOAD_LAT=1, CNT_W=16), B uses LOAD_LAT=3, CNT_W=4. Each step drives one
// instance for one cycle, queues the expected stall/busy/count for that cycle
// and compares them shortly before the next rising edge.
module tb_load_use_scoreboard;

  logic        clk;
  logic        a_rst, a_valid, a_flush;
  logic [15:0] a_instr;
  logic        a_stall;
  logic [7:0]  a_busy;
  logic [15:0] a_cnt;

  logic        b_rst, b_valid, b_flush;
  logic [15:0] b_instr;
  logic        b_stall;
  logic [7:0]  b_busy;
  logic [3:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        exp_stall;
    logic [7:0]  exp_busy;
    logic [15:0] exp_cnt;
  } exp_t;

  exp_t sb_q[$];

  load_use_scoreboard u_a (
    .clk         (clk),
    .rst         (a_rst),
    .issue_valid (a_valid),
    .issue_instr (a_instr),
    .flush       (a_flush),
    .stall       (a_stall),
    .busy_mask   (a_busy),
    .stall_count (a_cnt)
  );

  load_use_scoreboard #(
    .NREG     (8),
    .LOAD_LAT (3),
    .CNT_W    (4)
  ) u_b (
    .clk         (clk),
    .rst         (b_rst),
    .issue_valid (b_valid),
    .issue_instr (b_instr),
    .flush       (b_flush),
    .stall       (b_stall),
    .busy_mask   (b_busy),
    .stall_count (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sat15(input int v);
    return (v > 15) ? 16'd15 : 16'(v);
  endfunction

  // One cycle on instance `which` (0 = A, 1 = B). Called just after a
  // falling edge; returns just after the following falling edge.
  task automatic step(input int which, input logic r, input logic v,
                      input logic [15:0] instr, input logic f,
                      input logic es, input logic [7:0] eb,
                      input logic [15:0] ec, input string tag);
    exp_t        e;
    logic        o_stall;
    logic [7:0]  o_busy;
    logic [15:0] o_cnt;
    if (which == 0) begin
      a_rst = r; a_valid = v; a_instr = instr; a_flush = f;
    end else begin
      b_rst = r; b_valid = v; b_instr = instr; b_flush = f;
    end
    sb_q.push_back('{tag, es, eb, ec});
    #2;
    e = sb_q.pop_front();
    o_stall = (which == 0) ? a_stall : b_stall;
    o_busy  = (which == 0) ? a_busy  : b_busy;
    o_cnt   = (which == 0) ? a_cnt   : {12'd0, b_cnt};
    checks++;
    assert (o_stall === e.exp_stall) else begin
      failures++;
      $error("FAIL %s stall observed=%0b expected=%0b", e.tag, o_stall, e.exp_stall);
    end
    checks++;
    assert (o_busy === e.exp_busy) else begin
      failures++;
      $error("FAIL %s busy_mask observed=%02h expected=%02h", e.tag, o_busy, e.exp_busy);
    end
    checks++;
    assert (o_cnt === e.exp_cnt) else begin
      failures++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", e.tag, o_cnt, e.exp_cnt);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1; a_valid = 1'b0; a_instr = '0; a_flush = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_instr = '0; b_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // ---------------- instance A: LOAD_LAT=1, CNT_W=16 ----------------
    step(0, 1, 0, 16'h0000, 0, 0, 8'h00, 16'd0, "a_reset");
    // load r3 then dependent ALU: one stall cycle
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd0, "a_ld_r3");
    step(0, 0, 1, 16'hCB00, 0, 1, 8'h08, 16'd0, "a_use_stall");
    step(0, 0, 1, 16'hCB00, 0, 0, 8'h00, 16'd1, "a_use_go");
    // independent instruction after load
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_r3_b");
    step(0, 0, 1, 16'hCA00, 0, 0, 8'h08, 16'd1, "a_indep");
    step(0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'd1, "a_indep_after");
    // flush with dependent presented
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_flush");
    step(0, 0, 1, 16'hCB00, 1, 0, 8'h08, 16'd1, "a_flush");
    step(0, 0, 1, 16'hCB00, 0, 0, 8'h00, 16'd1, "a_post_flush");
    // branch reads nothing; store reads rd
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_br");
    step(0, 0, 1, 16'h8000, 0, 0, 8'h08, 16'd1, "a_branch");
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_st");
    step(0, 0, 1, 16'h5800, 0, 1, 8'h08, 16'd1, "a_store_stall");
    step(0, 0, 1, 16'h5800, 0, 0, 8'h00, 16'd2, "a_store_go");
    // reset wins over an accepting load
    step(0, 1, 1, 16'h1800, 0, 0, 8'h00, 16'd2, "a_rst_vs_ld");
    step(0, 0, 1, 16'hCB00, 0, 0, 8'h00, 16'd0, "a_after_rst_ld");
    // stall forced low while reset is asserted
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd0, "a_ld_rst");
    step(0, 1, 1, 16'hCB00, 0, 0, 8'h08, 16'd0, "a_rst_mask");
    step(0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'd0, "a_rst_clear");
    // highest register in the field
    step(0, 0, 1, 16'h3800, 0, 0, 8'h00, 16'd0, "a_ld_r7");
    step(0, 0, 1, 16'hC700, 0, 1, 8'h80, 16'd0, "a_r7_stall");
    step(0, 0, 1, 16'hC700, 0, 0, 8'h00, 16'd1, "a_r7_go");
    // ALU func 0111 reads nothing; func 0110 reads rd only
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_f7");
    step(0, 0, 1, 16'hD870, 0, 0, 8'h08, 16'd1, "a_func7");
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd1, "a_ld_f6");
    step(0, 0, 1, 16'hD860, 0, 1, 8'h08, 16'd1, "a_func6_stall");
    step(0, 0, 1, 16'hD860, 0, 0, 8'h00, 16'd2, "a_func6_go");
    // func 1000 reads rs only
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd2, "a_ld_f8a");
    step(0, 0, 1, 16'hD880, 0, 0, 8'h08, 16'd2, "a_func8_rd");
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd2, "a_ld_f8b");
    step(0, 0, 1, 16'hC380, 0, 1, 8'h08, 16'd2, "a_func8_stall");
    step(0, 0, 1, 16'hC380, 0, 0, 8'h00, 16'd3, "a_func8_go");
    // load whose base register is busy
    step(0, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd3, "a_ld_ld");
    step(0, 0, 1, 16'h0300, 0, 1, 8'h08, 16'd3, "a_ldld_stall");
    step(0, 0, 1, 16'h0300, 0, 0, 8'h00, 16'd4, "a_ldld_go");
    step(0, 0, 0, 16'h0000, 0, 0, 8'h01, 16'd4, "a_r0_busy");
    step(0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'd4, "a_idle");
    a_rst = 1'b1;

    // ---------------- instance B: LOAD_LAT=3, CNT_W=4 ----------------
    step(1, 1, 0, 16'h0000, 0, 0, 8'h00, 16'd0, "b_reset");
    step(1, 0, 1, 16'h1800, 0, 0, 8'h00, 16'd0, "b_ld_r3");
    step(1, 0, 1, 16'hCB00, 0, 1, 8'h08, 16'd0, "b_stall1");
    step(1, 0, 1, 16'hCB00, 0, 1, 8'h08, 16'd1, "b_stall2");
    step(1, 0, 1, 16'hCB00, 0, 1, 8'h08, 16'd2, "b_stall3");
    step(1, 0, 1, 16'hCB00, 0, 0, 8'h00, 16'd3, "b_go");
    // self-dependent load r3 <- [r3]: 3 stalls per 4 cycles, 18 more stalls
    for (int g = 0; g < 6; g++) begin
      step(1, 0, 1, 16'h1B00, 0, 0, 8'h00, sat15(3 + 3 * g), "b_loop_acc");
      for (int k = 0; k < 3; k++) begin
        step(1, 0, 1, 16'h1B00, 0, 1, 8'h08, sat15(3 + 3 * g + k), "b_loop_stall");
      end
    end
    step(1, 0, 1, 16'h1B00, 0, 0, 8'h00, 16'd15, "b_sat_acc");
    // reset in the middle of a stall
    step(1, 1, 1, 16'h1B00, 0, 0, 8'h08, 16'd15, "b_rst_mid");
    step(1, 0, 0, 16'h0000, 0, 0, 8'h00, 16'd0, "b_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
